// File: rtl/spi_tx_feeder.sv
// spi_tx_feeder: small word FIFO in front of an output-only SPI master.
// Each queued word is launched with a one-cycle TxStart and a stable
// TxData. The feeder then waits for TxDone, inserts an idle gap and
// aborts a transfer through a watchdog if TxDone never arrives.
module spi_tx_feeder #(
    parameter int BITS    = 4,
    parameter int DEPTH   = 4,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     Flush,
    input  logic                     InValid,
    input  logic [BITS-1:0]          InData,
    output logic                     InReady,
    output logic                     TxStart,
    output logic [BITS-1:0]          TxData,
    input  logic                     TxDone,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Busy,
    output logic                     Error
);

    localparam int AW       = $clog2(DEPTH);
    localparam int CW       = AW + 1;
    localparam int GW       = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int TW       = $clog2(TIMEOUT);
    // Last gap count value; clamped so the compare stays legal when GAP is 0
    localparam int GAP_LAST = (GAP > 0) ? (GAP - 1) : 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_s;

    logic [BITS-1:0]   mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic [CW-1:0]     count_s;

    logic [BITS-1:0]   tx_data_r;
    logic              tx_start_r;
    logic              busy_r;
    logic              error_r;

    logic [GW-1:0]     gap_cnt_r;
    logic [GW-1:0]     gap_cnt_s;
    logic [TW-1:0]     tmo_cnt_r;
    logic [TW-1:0]     tmo_cnt_s;

    logic              in_ready_s;
    logic              push_s;
    logic              pop_s;
    logic              timeout_s;

    // Ready is the only combinational output; Flush blocks the push it overrides
    assign in_ready_s = (count_r < CW'(DEPTH));
    assign push_s     = InValid && in_ready_s && !Flush;

    // Next-state logic: pop on leaving IDLE, watchdog in WAIT, gap counting in GAP
    always_comb begin
        state_s   = state_r;
        pop_s     = 1'b0;
        timeout_s = 1'b0;
        gap_cnt_s = gap_cnt_r;
        tmo_cnt_s = tmo_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if ((count_r != {CW{1'b0}}) && !Flush) begin
                    pop_s   = 1'b1;
                    state_s = ST_LAUNCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                // TxDone is deliberately not looked at while the start pulse is out
                tmo_cnt_s = {TW{1'b0}};
                state_s   = ST_WAIT;
            end
            ST_WAIT: begin
                if (TxDone) begin
                    gap_cnt_s = {GW{1'b0}};
                    if (GAP == 0) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_GAP;
                    end
                end else if (tmo_cnt_r == TW'(TIMEOUT - 1)) begin
                    // Controller never answered: drop the word, flag it, move on
                    timeout_s = 1'b1;
                    state_s   = ST_IDLE;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + TW'(1);
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == GW'(GAP_LAST)) begin
                    state_s = ST_IDLE;
                end else begin
                    gap_cnt_s = gap_cnt_r + GW'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Occupancy update: Flush wins, a simultaneous push and pop cancel out
    always_comb begin
        count_s = count_r;
        if (Flush) begin
            count_s = {CW{1'b0}};
        end else if (push_s && !pop_s) begin
            count_s = count_r + CW'(1);
        end else if (!push_s && pop_s) begin
            count_s = count_r - CW'(1);
        end else begin
            count_s = count_r;
        end
    end

    // FSM state and its counters
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_r   <= ST_IDLE;
            gap_cnt_r <= {GW{1'b0}};
            tmo_cnt_r <= {TW{1'b0}};
        end else begin
            state_r   <= state_s;
            gap_cnt_r <= gap_cnt_s;
            tmo_cnt_r <= tmo_cnt_s;
        end
    end

    // FIFO storage and pointers; pointers wrap naturally since DEPTH is a power of 2
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {BITS{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            count_r <= count_s;
            if (push_s) begin
                mem_r[wr_ptr_r] <= InData;
            end
            if (Flush) begin
                wr_ptr_r <= {AW{1'b0}};
                rd_ptr_r <= {AW{1'b0}};
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + AW'(1);
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + AW'(1);
                end
            end
        end
    end

    // Registered outputs: start pulse and busy follow the next state, data latches on pop
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            tx_start_r <= 1'b0;
            tx_data_r  <= {BITS{1'b0}};
            busy_r     <= 1'b0;
        end else begin
            tx_start_r <= (state_s == ST_LAUNCH);
            busy_r     <= (state_s != ST_IDLE);
            if (pop_s) begin
                tx_data_r <= mem_r[rd_ptr_r];
            end
        end
    end

    // Sticky watchdog flag; a fresh timeout is kept even if Flush arrives with it
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            error_r <= 1'b0;
        end else if (timeout_s) begin
            error_r <= 1'b1;
        end else if (Flush) begin
            error_r <= 1'b0;
        end else begin
            error_r <= error_r;
        end
    end

    assign InReady = in_ready_s;
    assign TxStart = tx_start_r;
    assign TxData  = tx_data_r;
    assign Count   = count_r;
    assign Busy    = busy_r;
    assign Error   = error_r;

endmodule

// File: tb/tb_spi_tx_feeder.sv
// Directed bench for spi_tx_feeder (BITS=4, DEPTH=4, GAP=2, TIMEOUT=64).
// A small responder answers each TxStart with a TxDone pulse after a
// programmable delay and logs launch cycles, launched words and done cycles.
module tb_spi_tx_feeder;

    logic       Clock;
    logic       Reset;
    logic       Flush;
    logic       InValid;
    logic [3:0] InData;
    logic       InReady;
    logic       TxStart;
    logic [3:0] TxData;
    logic       TxDone;
    logic [2:0] Count;
    logic       Busy;
    logic       Error;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic resp_en  = 1'b0;
    int   resp_dly = 5;
    int   resp_left;

    int         start_q[$];
    int         done_q[$];
    logic [3:0] data_q[$];

    spi_tx_feeder #(
        .BITS    (4),
        .DEPTH   (4),
        .GAP     (2),
        .TIMEOUT (64)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Flush   (Flush),
        .InValid (InValid),
        .InData  (InData),
        .InReady (InReady),
        .TxStart (TxStart),
        .TxData  (TxData),
        .TxDone  (TxDone),
        .Count   (Count),
        .Busy    (Busy),
        .Error   (Error)
    );

    // Free-running clock
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Cycle counter used to time-stamp launches and done pulses
    always @(posedge Clock) begin
        cyc <= cyc + 1;
    end

    // Controller stand-in: logs launches and answers them after resp_dly cycles
    initial begin
        TxDone    = 1'b0;
        resp_left = 0;
        forever begin
            @(posedge Clock);
            #2;
            TxDone = 1'b0;
            if (!Reset) begin
                resp_left = 0;
            end else begin
                if (resp_left != 0) begin
                    resp_left--;
                    if (resp_left == 0) begin
                        TxDone = 1'b1;
                        done_q.push_back(cyc);
                    end
                end
                if (TxStart) begin
                    start_q.push_back(cyc);
                    data_q.push_back(TxData);
                    if (resp_en) begin
                        resp_left = resp_dly;
                    end
                end
            end
        end
    end

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, want completion");
        n_errors++;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        int n;
        n = 0;
        while (Busy && (n < max_cyc)) begin
            step();
            n++;
        end
        check_val(tag, 32'(Busy), 32'd0);
    endtask

    task automatic wait_drain(input string tag, input int n_words, input int max_cyc);
        int n;
        n = 0;
        while (!((start_q.size() >= n_words) && !Busy) && (n < max_cyc)) begin
            step();
            n++;
        end
        check_val(tag, 32'(start_q.size()), 32'(n_words));
    endtask

    task automatic clear_logs();
        start_q.delete();
        done_q.delete();
        data_q.delete();
    endtask

    task automatic push_word(input logic [3:0] w);
        InValid = 1'b1;
        InData  = w;
        step();
    endtask

    logic [3:0] exp4_q[$];
    int         n0;

    initial begin
        Reset   = 1'b0;
        Flush   = 1'b0;
        InValid = 1'b0;
        InData  = 4'h0;

        // 1: reset state and quiet idle
        for (int i = 0; i < 3; i++) begin
            step();
        end
        check_val("t1_rst_count", 32'(Count), 32'd0);
        check_val("t1_rst_busy", 32'(Busy), 32'd0);
        check_val("t1_rst_ready", 32'(InReady), 32'd1);
        check_val("t1_rst_start", 32'(TxStart), 32'd0);
        check_val("t1_rst_data", 32'(TxData), 32'h0);
        check_val("t1_rst_error", 32'(Error), 32'd0);
        Reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check_val("t1_idle_start", 32'(TxStart), 32'd0);
            check_val("t1_idle_busy", 32'(Busy), 32'd0);
        end
        check_val("t1_count", 32'(Count), 32'd0);
        check_val("t1_ready", 32'(InReady), 32'd1);
        check_val("t1_data", 32'(TxData), 32'h0);

        // 2: single word, done 5 cycles after launch, busy drops 3 after done
        clear_logs();
        resp_en  = 1'b1;
        resp_dly = 5;
        push_word(4'hA);                      // now cycle 1
        InValid = 1'b0;
        check_val("t2_count_c1", 32'(Count), 32'd1);
        check_val("t2_start_c1", 32'(TxStart), 32'd0);
        step();                               // cycle 2
        check_val("t2_start_c2", 32'(TxStart), 32'd1);
        check_val("t2_data_c2", 32'(TxData), 32'hA);
        check_val("t2_busy_c2", 32'(Busy), 32'd1);
        check_val("t2_count_c2", 32'(Count), 32'd0);
        step();                               // cycle 3
        check_val("t2_start_c3", 32'(TxStart), 32'd0);
        for (int c = 4; c <= 10; c++) begin
            step();
            check_val("t2_busy", 32'(Busy), (c < 10) ? 32'd1 : 32'd0);
            check_val("t2_data_hold", 32'(TxData), 32'hA);
        end
        check_val("t2_launches", 32'(start_q.size()), 32'd1);
        check_val("t2_count_end", 32'(Count), 32'd0);

        // 3: fill, back-pressure, ordering and launch spacing
        clear_logs();
        resp_dly = 20;
        for (int w = 1; w <= 5; w++) begin
            check_val("t3_ready_pre", 32'(InReady), 32'd1);
            push_word(4'(w));
        end
        check_val("t3_count_full", 32'(Count), 32'd4);
        check_val("t3_ready_full", 32'(InReady), 32'd0);
        InData = 4'h6;                        // held while full, must not enter
        step();
        check_val("t3_ready_hold", 32'(InReady), 32'd0);
        step();
        InValid = 1'b0;
        check_val("t3_ready_hold2", 32'(InReady), 32'd0);
        step();
        check_val("t3_count_hold", 32'(Count), 32'd4);
        wait_drain("t3_drain", 5, 400);
        exp4_q = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
        for (int i = 0; i < data_q.size() && i < 5; i++) begin
            check_val("t3_order", 32'(data_q[i]), 32'(exp4_q[i]));
        end
        for (int i = 0; (i + 1) < start_q.size() && i < done_q.size(); i++) begin
            check_val("t3_spacing", 32'(start_q[i + 1] - done_q[i]), 32'd4);
        end
        check_val("t3_count_end", 32'(Count), 32'd0);

        // 4: push on the IDLE->LAUNCH edge keeps Count steady
        clear_logs();
        resp_dly = 6;
        push_word(4'h3);
        push_word(4'h7);
        push_word(4'hB);
        InValid = 1'b0;
        check_val("t4_count_q2", 32'(Count), 32'd2);
        check_val("t4_busy", 32'(Busy), 32'd1);
        wait_idle("t4_wait_idle", 50);
        check_val("t4_count_pre", 32'(Count), 32'd2);
        push_word(4'hE);
        InValid = 1'b0;
        check_val("t4_count_post", 32'(Count), 32'd2);
        check_val("t4_start", 32'(TxStart), 32'd1);
        check_val("t4_data", 32'(TxData), 32'h7);
        wait_drain("t4_drain", 4, 200);
        exp4_q = '{4'h3, 4'h7, 4'hB, 4'hE};
        for (int i = 0; i < data_q.size() && i < 4; i++) begin
            check_val("t4_order", 32'(data_q[i]), 32'(exp4_q[i]));
        end
        check_val("t4_count_end", 32'(Count), 32'd0);

        // 5: watchdog timeout, next word still launches, Flush clears
        clear_logs();
        resp_en = 1'b0;
        push_word(4'h9);                      // cycle 1
        push_word(4'hC);                      // cycle 2
        InValid = 1'b0;
        check_val("t5_start", 32'(TxStart), 32'd1);
        check_val("t5_data", 32'(TxData), 32'h9);
        check_val("t5_count", 32'(Count), 32'd1);
        for (int i = 0; i < 64; i++) begin
            step();
        end                                   // cycle 66, last WAIT cycle
        check_val("t5_err_before", 32'(Error), 32'd0);
        check_val("t5_busy_before", 32'(Busy), 32'd1);
        step();                               // cycle 67
        check_val("t5_err_set", 32'(Error), 32'd1);
        check_val("t5_busy_idle", 32'(Busy), 32'd0);
        check_val("t5_count_idle", 32'(Count), 32'd1);
        step();                               // cycle 68
        check_val("t5_next_start", 32'(TxStart), 32'd1);
        check_val("t5_next_data", 32'(TxData), 32'hC);
        check_val("t5_err_sticky", 32'(Error), 32'd1);
        push_word(4'h1);
        push_word(4'h2);
        check_val("t5_count_pre_flush", 32'(Count), 32'd2);
        InData = 4'h5;                        // push collides with Flush
        Flush  = 1'b1;
        step();
        Flush   = 1'b0;
        InValid = 1'b0;
        check_val("t5_flush_count", 32'(Count), 32'd0);
        check_val("t5_flush_err", 32'(Error), 32'd0);
        check_val("t5_flush_busy", 32'(Busy), 32'd1);
        check_val("t5_flush_data", 32'(TxData), 32'hC);
        check_val("t5_flush_ready", 32'(InReady), 32'd1);
        wait_idle("t5_wait_idle", 100);
        check_val("t5_err_again", 32'(Error), 32'd1);
        check_val("t5_launches", 32'(start_q.size()), 32'd2);

        // 6: asynchronous reset in WAIT with three words queued
        clear_logs();
        push_word(4'h5);
        push_word(4'h6);
        push_word(4'h7);
        push_word(4'h8);
        InValid = 1'b0;
        check_val("t6_count_pre", 32'(Count), 32'd3);
        check_val("t6_busy_pre", 32'(Busy), 32'd1);
        #3;
        Reset = 1'b0;
        #1;
        check_val("t6_rst_count", 32'(Count), 32'd0);
        check_val("t6_rst_busy", 32'(Busy), 32'd0);
        check_val("t6_rst_start", 32'(TxStart), 32'd0);
        check_val("t6_rst_error", 32'(Error), 32'd0);
        check_val("t6_rst_data", 32'(TxData), 32'h0);
        n0 = start_q.size();
        step();
        step();
        Reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check_val("t6_quiet_start", 32'(TxStart), 32'd0);
        end
        check_val("t6_no_launch", 32'(start_q.size()), 32'(n0));
        check_val("t6_count_quiet", 32'(Count), 32'd0);
        push_word(4'hF);
        InValid = 1'b0;
        step();
        check_val("t6_new_start", 32'(TxStart), 32'd1);
        check_val("t6_new_data", 32'(TxData), 32'hF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
